// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch front end.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam int          COUNT_W   = 14;
    localparam logic [13:0] MAX_COUNT = 14'd9999;
    localparam logic [1:0]  DEC_POS   = 2'd2;

    // The prescaler and the running flag both follow this decode.
    function automatic logic is_running(input state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the count rate. The counter advances only
// while run is high, holds otherwise, and is forced to zero by zero.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic zero,
    output logic tick
);

    localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("tick_prescaler: DIV must be at least 2");
        end
    endgenerate

    logic [W-1:0] r_cnt;

    assign tick = run && (r_cnt == LAST);

    // Prescaler counter: zero wins, otherwise count 0..DIV-1 while running.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (zero) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Centisecond stopwatch feeding the seven-segment driver: button edge
// detection, run/pause/lap FSM, 0..9999 count with sticky wrap flag, and a
// registered display value that shows either the live count or a lap hold.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] din,
    output logic        bcd,
    output logic [1:0]  dec,
    output logic        enable,
    output logic        running,
    output logic        lap_active,
    output logic        ovf
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_ss_q;
    logic                 r_lap_q;
    logic                 r_clr_q;
    logic                 r_armed;
    logic                 w_ss_ev;
    logic                 w_lap_ev;
    logic                 w_clr_ev;
    logic                 w_run;
    logic                 w_zero;
    logic                 w_clear_idle;
    logic                 w_lap_latch;
    logic                 w_tick;
    logic [COUNT_W-1:0]   r_count;
    logic [COUNT_W-1:0]   r_lap_hold;
    logic [COUNT_W-1:0]   r_din;
    logic                 r_running;
    logic                 r_lap_active;
    logic                 r_ovf;

    // Edge registers reset to 0, so the first cycle after reset is spent
    // sampling the buttons; a button held through reset then shows no edge.
    assign w_ss_ev  = r_armed & start_stop & ~r_ss_q;
    assign w_lap_ev = r_armed & lap        & ~r_lap_q;
    assign w_clr_ev = r_armed & clear      & ~r_clr_q;

    // start_stop outranks clear, so PAUSE only returns to IDLE on a lone clear.
    assign w_clear_idle = (r_state == PAUSE) & w_clr_ev & ~w_ss_ev;
    assign w_lap_latch  = (r_state == RUN) & w_lap_ev & ~w_ss_ev;
    assign w_run        = is_running(r_state);
    assign w_zero       = (r_state == IDLE) | w_clear_idle;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .zero  (w_zero),
        .tick  (w_tick)
    );

    // Button sampling for edge detection plus the post-reset arming flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_q  <= 1'b0;
            r_lap_q <= 1'b0;
            r_clr_q <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_ss_q  <= start_stop;
            r_lap_q <= lap;
            r_clr_q <= clear;
            r_armed <= 1'b1;
        end
    end

    // Next-state decode; start_stop takes precedence over lap and clear.
    // NOTE: next state defaults to the current one first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_ss_ev) w_next_state = RUN;
            end
            RUN: begin
                if (w_ss_ev)       w_next_state = PAUSE;
                else if (w_lap_ev) w_next_state = LAP;
            end
            LAP: begin
                if (w_ss_ev)       w_next_state = PAUSE;
                else if (w_lap_ev) w_next_state = RUN;
            end
            PAUSE: begin
                if (w_ss_ev)       w_next_state = RUN;
                else if (w_clr_ev) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register with registered decodes that move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_running    <= is_running(w_next_state);
            r_lap_active <= (w_next_state == LAP);
        end
    end

    // Hundredths counter with wrap at 9999 and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_clear_idle) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_tick) begin
            if (r_count == MAX_COUNT) begin
                r_count <= '0;
                r_ovf   <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Lap snapshot; takes the pre-increment count when a tick coincides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_hold <= '0;
        end else if (w_lap_latch) begin
            r_lap_hold <= r_count;
        end
    end

    // Display register: frozen lap value while in LAP, live count otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din <= '0;
        end else begin
            r_din <= r_lap_active ? r_lap_hold : r_count;
        end
    end

    assign din        = {2'b00, r_din};
    assign bcd        = 1'b1;
    assign dec        = DEC_POS;
    assign enable     = 1'b1;
    assign running    = r_running;
    assign lap_active = r_lap_active;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl. A DIV=10 instance covers the
// functional scenarios; a DIV=2 instance reaches the 9999 wrap quickly.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;

    logic [15:0] din,        f_din;
    logic        bcd,        f_bcd;
    logic [1:0]  dec,        f_dec;
    logic        enable,     f_enable;
    logic        running,    f_running;
    logic        lap_active, f_lap_active;
    logic        ovf,        f_ovf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        bit          fast;
        logic [15:0] din;
        logic        running;
        logic        lap_active;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .din        (din),
        .bcd        (bcd),
        .dec        (dec),
        .enable     (enable),
        .running    (running),
        .lap_active (lap_active),
        .ovf        (ovf)
    );

    stopwatch_ctrl #(.CLK_HZ(200), .TICK_HZ(100)) u_dut_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .din        (f_din),
        .bcd        (f_bcd),
        .dec        (f_dec),
        .enable     (f_enable),
        .running    (f_running),
        .lap_active (f_lap_active),
        .ovf        (f_ovf)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_main(input string tag, input logic [15:0] d,
                               input logic r, input logic l, input logic o);
        sb.push_back('{tag, 1'b0, d, r, l, o});
    endtask

    task automatic expect_fast(input string tag, input logic [15:0] d,
                               input logic r, input logic l, input logic o);
        sb.push_back('{tag, 1'b1, d, r, l, o});
    endtask

    // Pop the oldest expectation and compare it with the selected instance.
    task automatic observe();
        exp_t        e;
        logic [15:0] o_din;
        logic        o_run, o_lap, o_ovf, o_bcd, o_en;
        logic [1:0]  o_dec;
        if (sb.size() == 0) begin
            check("sb_underflow", 16'(sb.size()), 16'd1);
            return;
        end
        e = sb.pop_front();
        if (e.fast) begin
            o_din = f_din; o_run = f_running; o_lap = f_lap_active;
            o_ovf = f_ovf; o_bcd = f_bcd; o_dec = f_dec; o_en = f_enable;
        end else begin
            o_din = din; o_run = running; o_lap = lap_active;
            o_ovf = ovf; o_bcd = bcd; o_dec = dec; o_en = enable;
        end
        check({e.tag, ".din"},        o_din,        e.din);
        check({e.tag, ".running"},    16'(o_run),   16'(e.running));
        check({e.tag, ".lap_active"}, 16'(o_lap),   16'(e.lap_active));
        check({e.tag, ".ovf"},        16'(o_ovf),   16'(e.ovf));
        check({e.tag, ".bcd"},        16'(o_bcd),   16'd1);
        check({e.tag, ".dec"},        16'(o_dec),   16'd2);
        check({e.tag, ".enable"},     16'(o_en),    16'd1);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; step(1); start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1; step(1); lap = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(1); clear = 1'b0;
    endtask

    // Reset both instances, check reset values, release on a falling edge.
    task automatic do_reset(input bit hold_ss);
        start_stop = hold_ss;
        lap        = 1'b0;
        clear      = 1'b0;
        rst_n      = 1'b0;
        step(3);
        expect_main("rst", 16'd0, 1'b0, 1'b0, 1'b0); observe();
        expect_fast("rst_fast", 16'd0, 1'b0, 1'b0, 1'b0); observe();
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        // Reset values; lap in IDLE is ignored.
        do_reset(1'b0);
        pulse_lap();
        expect_main("idle_lap", 16'd0, 1'b0, 1'b0, 1'b0); step(2); observe();

        // Start, 250 cycles -> count 25, visible on din one cycle later.
        pulse_ss();
        expect_main("run_pre25", 16'd24, 1'b1, 1'b0, 1'b0); step(250); observe();
        expect_main("run_din25", 16'd25, 1'b1, 1'b0, 1'b0); step(1);   observe();

        // Pause at 40, hold 100 cycles, resume: next tick 10 running cycles on.
        step(149);
        pulse_ss();
        expect_main("pause_hold", 16'd40, 1'b0, 1'b0, 1'b0); step(100); observe();
        pulse_ss();
        expect_main("resume_pre",  16'd40, 1'b1, 1'b0, 1'b0); step(9); observe();
        expect_main("resume_tick", 16'd41, 1'b1, 1'b0, 1'b0); step(1); observe();

        // A tick on the same edge as the pause is still counted.
        do_reset(1'b0);
        pulse_ss();
        step(49);
        pulse_ss();
        expect_main("tick_pause", 16'd5, 1'b0, 1'b0, 1'b0); step(20); observe();

        // Lap freeze at 30 while counting to 50, then release.
        do_reset(1'b0);
        pulse_ss();
        step(300);
        pulse_lap();
        expect_main("lap_hold", 16'd30, 1'b1, 1'b1, 1'b0); step(200); observe();
        pulse_lap();
        expect_main("lap_release", 16'd30, 1'b1, 1'b0, 1'b0); observe();
        expect_main("lap_live",    16'd50, 1'b1, 1'b0, 1'b0); step(1); observe();

        // Lap on a tick edge latches the pre-increment count; start_stop
        // from LAP pauses and drops the freeze.
        do_reset(1'b0);
        pulse_ss();
        step(99);
        pulse_lap();
        expect_main("lap_tick_hold", 16'd9, 1'b1, 1'b1, 1'b0); step(5); observe();
        pulse_ss();
        expect_main("lap_to_pause", 16'd10, 1'b0, 1'b0, 1'b0); step(2); observe();

        // Clear ignored in RUN; start_stop+clear in PAUSE resumes uncleared.
        do_reset(1'b0);
        pulse_ss();
        step(50);
        pulse_clear();
        expect_main("run_clear_ign", 16'd10, 1'b1, 1'b0, 1'b0); step(50); observe();
        pulse_ss();
        step(5);
        start_stop = 1'b1; clear = 1'b1;
        step(1);
        start_stop = 1'b0; clear = 1'b0;
        expect_main("ss_clear_pause", 16'd10, 1'b1, 1'b0, 1'b0); step(1); observe();

        // start_stop held through reset release must not start the watch.
        do_reset(1'b1);
        expect_main("hold_no_run", 16'd0, 1'b0, 1'b0, 1'b0); step(4); observe();
        start_stop = 1'b0;
        step(1);
        pulse_ss();
        expect_main("mid_run77", 16'd77, 1'b1, 1'b0, 1'b0); step(771); observe();

        // Asynchronous reset between clock edges clears outputs at once.
        #2;
        rst_n = 1'b0;
        #1;
        expect_main("async_rst", 16'd0, 1'b0, 1'b0, 1'b0); observe();
        @(negedge clk);

        // Overflow on the DIV=2 instance: 9998 -> 9999 -> 0 with sticky ovf.
        do_reset(1'b0);
        pulse_ss();
        expect_fast("ovf_9998", 16'd9998, 1'b1, 1'b0, 1'b0); step(19997); observe();
        expect_fast("ovf_9999", 16'd9999, 1'b1, 1'b0, 1'b0); step(2);     observe();
        expect_fast("ovf_set",  16'd9999, 1'b1, 1'b0, 1'b1); step(1);     observe();
        expect_fast("ovf_wrap", 16'd0,    1'b1, 1'b0, 1'b1); step(1);     observe();
        pulse_ss();
        expect_fast("ovf_pause",  16'd0, 1'b0, 1'b0, 1'b1); observe();
        expect_fast("ovf_sticky", 16'd1, 1'b0, 1'b0, 1'b1); step(1); observe();
        pulse_clear();
        expect_fast("clear_idle", 16'd0, 1'b0, 1'b0, 1'b0); step(1); observe();

        check("sb_leftover", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
